// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register: valid/ready handshake, 2-entry skid buffer, synchronous flush, forwarding outputs.
// Optional build macro EX_MEM_STALL_CNT_EN adds a saturating MEM back-pressure stall counter (stall_cnt_o).
module ex_mem_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int WB_W   = 2,
  parameter int MEM_W  = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [WB_W-1:0]   wb_i,
  input  logic [MEM_W-1:0]  mem_i,
  input  logic [DATA_W-1:0] result_i,
  input  logic [DATA_W-1:0] rtdata_i,
  input  logic [ADDR_W-1:0] writeaddr_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [WB_W-1:0]   wb_o,
  output logic [MEM_W-1:0]  mem_o,
  output logic [DATA_W-1:0] result_o,
  output logic [DATA_W-1:0] rtdata_o,
  output logic [ADDR_W-1:0] writeaddr_o,
  output logic              fwd_en_o,
  output logic [ADDR_W-1:0] fwd_addr_o,
  output logic [DATA_W-1:0] fwd_data_o
`ifdef EX_MEM_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt_o
`endif
);

  typedef struct packed {
    logic [WB_W-1:0]   wb;
    logic [MEM_W-1:0]  mem;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] rtdata;
    logic [ADDR_W-1:0] writeaddr;
  } payload_t;

  // EMPTY: nothing held; ONE: output entry only; FULL: output and skid entries.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e   state_q, state_d;
  payload_t out_q, out_d;
  payload_t skid_q, skid_d;
  payload_t in_pl;
  logic     accept, drain;

  assign in_pl   = '{wb: wb_i, mem: mem_i, result: result_i,
                     rtdata: rtdata_i, writeaddr: writeaddr_i};
  assign ready_o = (state_q != FULL);
  assign valid_o = (state_q != EMPTY);
  assign accept  = valid_i & ready_o;
  assign drain   = valid_o & ready_i;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          out_d   = in_pl;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && drain) begin
          out_d = in_pl;
        end else if (accept) begin
          skid_d  = in_pl;
          state_d = FULL;
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (drain) begin
          out_d   = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush only kills the valid bits; stale payload is masked by valid_o.
    if (flush_i) state_d = EMPTY;
  end

  // NOTE: payload registers are reset too so every data output reads zero out of reset, not just the valid bits.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

  assign wb_o        = out_q.wb;
  assign mem_o       = out_q.mem;
  assign result_o    = out_q.result;
  assign rtdata_o    = out_q.rtdata;
  assign writeaddr_o = out_q.writeaddr;

  // Register 0 is hard-wired zero, so writes to it must never be forwarded.
  assign fwd_en_o   = valid_o & out_q.wb[0] & (out_q.writeaddr != '0);
  assign fwd_addr_o = out_q.writeaddr;
  assign fwd_data_o = out_q.result;

`ifdef EX_MEM_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (valid_o && !ready_i && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // Cleared by reset only; flush leaves the statistic intact.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Directed self-checking bench for ex_mem_pipe_reg (stall counter test only when EX_MEM_STALL_CNT_EN is defined).
module tb_ex_mem_pipe_reg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int WB_W   = 2;
  localparam int MEM_W  = 3;

  logic              clk_i = 1'b0;
  logic              rst_i, flush_i, valid_i, ready_i;
  logic              ready_o, valid_o, fwd_en_o;
  logic [WB_W-1:0]   wb_i, wb_o;
  logic [MEM_W-1:0]  mem_i, mem_o;
  logic [DATA_W-1:0] result_i, rtdata_i, result_o, rtdata_o, fwd_data_o;
  logic [ADDR_W-1:0] writeaddr_i, writeaddr_o, fwd_addr_o;
`ifdef EX_MEM_STALL_CNT_EN
  logic [31:0]       stall_cnt_o;
`endif

  int vectors = 0;
  int miscompares = 0;

  ex_mem_pipe_reg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WB_W(WB_W), .MEM_W(MEM_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .valid_i(valid_i), .ready_o(ready_o),
    .wb_i(wb_i), .mem_i(mem_i), .result_i(result_i), .rtdata_i(rtdata_i),
    .writeaddr_i(writeaddr_i),
    .valid_o(valid_o), .ready_i(ready_i),
    .wb_o(wb_o), .mem_o(mem_o), .result_o(result_o), .rtdata_o(rtdata_o),
    .writeaddr_o(writeaddr_o),
    .fwd_en_o(fwd_en_o), .fwd_addr_o(fwd_addr_o), .fwd_data_o(fwd_data_o)
`ifdef EX_MEM_STALL_CNT_EN
    , .stall_cnt_o(stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Inputs change 1 ns after the rising edge; outputs are sampled at the same point.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [WB_W-1:0] wb, input logic [DATA_W-1:0] res,
                       input logic [ADDR_W-1:0] wa);
    valid_i     = v;
    wb_i        = wb;
    mem_i       = res[2:0];
    result_i    = res;
    rtdata_i    = ~res;
    writeaddr_i = wa;
  endtask

  // Packs {valid_o, ready_o, fwd_en_o} for compact handshake comparisons.
  function automatic logic [2:0] hs();
    return {valid_o, ready_o, fwd_en_o};
  endfunction

  task automatic test_reset();
    rst_i = 1'b1; flush_i = 1'b0; ready_i = 1'b1;
    drive(1'b0, '0, '0, '0);
    step(); step();
    vectors++;
    if (hs() !== 3'b010) begin
      miscompares++;
      $display("FAIL reset_hs: got %b want 010", hs());
    end
    vectors++;
    if ({result_o, rtdata_o, writeaddr_o, wb_o, mem_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: result %h rtdata %h wa %0d wb %b mem %b want all 0",
               result_o, rtdata_o, writeaddr_o, wb_o, mem_o);
    end
    rst_i = 1'b0;
    step();
  endtask

  task automatic test_single();
    ready_i = 1'b1;
    drive(1'b1, 2'b01, 32'h0000_1234, 5'd5);
    step();
    drive(1'b0, '0, '0, '0);
    vectors++;
    if ({hs(), result_o, fwd_addr_o, fwd_data_o, rtdata_o, mem_o}
        !== {3'b111, 32'h1234, 5'd5, 32'h1234, ~32'h1234, 3'b100}) begin
      miscompares++;
      $display("FAIL single: hs %b res %h fwd_addr %0d fwd_data %h rt %h mem %b want 111/1234/5/1234/ffffedcb/100",
               hs(), result_o, fwd_addr_o, fwd_data_o, rtdata_o, mem_o);
    end
    step();
    vectors++;
    if (valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL single_drain: valid_o %b want 0", valid_o);
    end
  endtask

  task automatic test_back_to_back();
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'b01, 32'h100 + i, 5'(i + 1));
      step();
      vectors++;
      if ({valid_o, ready_o, result_o, writeaddr_o} !== {2'b11, 32'h100 + i, 5'(i + 1)}) begin
        miscompares++;
        $display("FAIL b2b_%0d: v %b r %b res %h wa %0d want 1 1 %h %0d",
                 i, valid_o, ready_o, result_o, writeaddr_o, 32'h100 + i, i + 1);
      end
    end
    drive(1'b0, '0, '0, '0);
    step();
    vectors++;
    if (valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_end: valid_o %b want 0", valid_o);
    end
  endtask

  task automatic test_skid();
    ready_i = 1'b0;
    drive(1'b1, 2'b01, 32'hA, 5'd10);
    step();
    vectors++;
    if ({valid_o, ready_o, result_o} !== {2'b11, 32'hA}) begin
      miscompares++;
      $display("FAIL skid_a: v %b r %b res %h want 1 1 a", valid_o, ready_o, result_o);
    end
    drive(1'b1, 2'b01, 32'hB, 5'd11);
    step();
    vectors++;
    if ({valid_o, ready_o, result_o} !== {2'b10, 32'hA}) begin
      miscompares++;
      $display("FAIL skid_full: v %b r %b res %h want 1 0 a", valid_o, ready_o, result_o);
    end
    drive(1'b1, 2'b01, 32'hC, 5'd12);
    step();
    vectors++;
    if ({valid_o, ready_o, result_o, writeaddr_o} !== {2'b10, 32'hA, 5'd10}) begin
      miscompares++;
      $display("FAIL skid_hold: v %b r %b res %h wa %0d want 1 0 a 10",
               valid_o, ready_o, result_o, writeaddr_o);
    end
    drive(1'b0, '0, '0, '0);
    ready_i = 1'b1;
    step();
    vectors++;
    if ({valid_o, ready_o, result_o, writeaddr_o} !== {2'b11, 32'hB, 5'd11}) begin
      miscompares++;
      $display("FAIL skid_drain_a: v %b r %b res %h wa %0d want 1 1 b 11",
               valid_o, ready_o, result_o, writeaddr_o);
    end
    step();
    vectors++;
    if ({valid_o, ready_o} !== 2'b01) begin
      miscompares++;
      $display("FAIL skid_drain_b: v %b r %b want 0 1", valid_o, ready_o);
    end
  endtask

  task automatic test_flush();
    ready_i = 1'b0;
    drive(1'b1, 2'b01, 32'h11, 5'd3);
    step();
    drive(1'b1, 2'b01, 32'h22, 5'd4);
    step();
    drive(1'b1, 2'b01, 32'h33, 5'd6);
    flush_i = 1'b1;
    step();
    vectors++;
    if (hs() !== 3'b010) begin
      miscompares++;
      $display("FAIL flush_full: hs %b want 010", hs());
    end
    flush_i = 1'b0;
    drive(1'b0, '0, '0, '0);
    step();
    vectors++;
    if (valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_discard: valid_o %b want 0", valid_o);
    end
    // Accept while empty in the flush cycle is dropped as well.
    ready_i = 1'b1;
    drive(1'b1, 2'b01, 32'h44, 5'd8);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    drive(1'b0, '0, '0, '0);
    vectors++;
    if (hs() !== 3'b010) begin
      miscompares++;
      $display("FAIL flush_empty: hs %b want 010", hs());
    end
  endtask

  task automatic test_forwarding();
    ready_i = 1'b1;
    drive(1'b1, 2'b01, 32'h55, 5'd0);
    step();
    vectors++;
    if ({valid_o, fwd_en_o} !== 2'b10) begin
      miscompares++;
      $display("FAIL fwd_r0: v %b fwd_en %b want 1 0", valid_o, fwd_en_o);
    end
    drive(1'b1, 2'b10, 32'h66, 5'd7);
    step();
    vectors++;
    if ({valid_o, fwd_en_o, fwd_addr_o} !== {2'b10, 5'd7}) begin
      miscompares++;
      $display("FAIL fwd_nowrite: v %b fwd_en %b addr %0d want 1 0 7", valid_o, fwd_en_o, fwd_addr_o);
    end
    drive(1'b0, '0, '0, '0);
    step();
  endtask

  task automatic test_reset_mid();
    ready_i = 1'b0;
    drive(1'b1, 2'b01, 32'h77, 5'd9);
    step();
    drive(1'b1, 2'b01, 32'h88, 5'd9);
    #2 rst_i = 1'b1;
    #1;
    vectors++;
    if ({hs(), result_o} !== {3'b010, 32'h0}) begin
      miscompares++;
      $display("FAIL reset_mid: hs %b res %h want 010 0", hs(), result_o);
    end
    drive(1'b0, '0, '0, '0);
    step();
    rst_i = 1'b0;
    ready_i = 1'b1;
    step();
    vectors++;
    if (valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_after: valid_o %b want 0", valid_o);
    end
  endtask

`ifdef EX_MEM_STALL_CNT_EN
  task automatic test_stall_cnt();
    ready_i = 1'b0;
    drive(1'b1, 2'b01, 32'h99, 5'd2);
    step();
    drive(1'b0, '0, '0, '0);
    repeat (10) step();
    vectors++;
    if (stall_cnt_o !== 32'd10) begin
      miscompares++;
      $display("FAIL stall_cnt: got %0d want 10", stall_cnt_o);
    end
    ready_i = 1'b1;
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    step();
    vectors++;
    if (stall_cnt_o !== 32'd10) begin
      miscompares++;
      $display("FAIL stall_cnt_flush: got %0d want 10", stall_cnt_o);
    end
    rst_i = 1'b1;
    #1;
    vectors++;
    if (stall_cnt_o !== 32'd0) begin
      miscompares++;
      $display("FAIL stall_cnt_rst: got %0d want 0", stall_cnt_o);
    end
    step();
    rst_i = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_skid();
    test_flush();
    test_forwarding();
    test_reset_mid();
`ifdef EX_MEM_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ex_mem_pipe_reg.md
Name: ex_mem_pipe_reg

Overview:
Parametrised EX/MEM pipeline stage register for the CPU datapath, replacing the fixed-width, always-advance register. Carries WB/MEM control, ALU result, store data and destination register address with a valid/ready handshake, and a 2-entry skid buffer so MEM-side back-pressure never drops an instruction. Supports synchronous flush for bubble insertion and drives registered forwarding outputs to the hazard unit.

Parameters:
DATA_W, 32, width of result and rt store data
ADDR_W, 5, width of destination register address
WB_W, 2, width of WB control bundle; bit 0 = RegWrite
MEM_W, 3, width of MEM control bundle

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-high reset
flush_i  in  1  synchronous flush: discard all held entries
valid_i  in  1  EX stage presents an instruction
ready_o  out  1  stage can accept; equals NOT skid_valid
wb_i  in  WB_W  WB control
mem_i  in  MEM_W  MEM control
result_i  in  DATA_W  ALU result / address
rtdata_i  in  DATA_W  store data
writeaddr_i  in  ADDR_W  destination register
valid_o  out  1  output entry valid
ready_i  in  1  MEM stage accepts
wb_o  out  WB_W  registered WB control
mem_o  out  MEM_W  registered MEM control
result_o  out  DATA_W  registered result
rtdata_o  out  DATA_W  registered store data
writeaddr_o  out  ADDR_W  registered destination
fwd_en_o  out  1  valid_o AND wb_o[0] AND writeaddr_o != 0
fwd_addr_o  out  ADDR_W  equals writeaddr_o
fwd_data_o  out  DATA_W  equals result_o

Behaviour:
- Storage: output register (out_valid + payload) and skid register (skid_valid + payload). All outputs driven from output register only; no combinational input-to-output path except ready_o (function of skid_valid only).
- Reset (async, rst_i=1): out_valid=0, skid_valid=0, all payload regs 0; hence valid_o=0, fwd_en_o=0, ready_o=1, all data outputs 0.
- Accept = valid_i AND ready_o; Drain = valid_o AND ready_i.
- States: EMPTY (out 0, skid 0), ONE (out 1, skid 0), FULL (out 1, skid 1).
- EMPTY: Accept -> load out, ONE. Else stay.
- ONE: Accept AND Drain -> load out with input, ONE. Accept only -> load skid, FULL. Drain only -> EMPTY. Neither -> hold.
- FULL: ready_o=0, no Accept possible. Drain -> out <= skid, skid_valid=0, ONE. Else hold.
- Latency: EMPTY->valid_o is 1 cycle; entries leave in strict FIFO order.
- flush_i=1 at a clock edge: out_valid=0, skid_valid=0 next cycle regardless of Accept/Drain in same cycle (flush dominates); payload regs may keep stale values but are masked by valid; fwd_en_o=0 next cycle.
- Drain in the flush cycle still counts as completed on the MEM side (MEM sampled valid_o=1, ready_i=1).
- Held payload stable while valid_o=1 and ready_i=0.
- Reset asserted mid-transfer: entries discarded immediately, no partial output.

Optional Feature:
EX_MEM_STALL_CNT_EN: adds output stall_cnt_o [31:0], incrementing each cycle valid_o=1 AND ready_i=0, saturating at 0xFFFFFFFF, cleared by rst_i only (not flush). Without macro: port and counter absent, no other change.

Test Plan:
- Reset then valid_i=1, result_i=0x0000_1234, writeaddr_i=5, wb_i=2'b01, ready_i=1 -> next cycle valid_o=1, result_o=0x1234, fwd_en_o=1, fwd_addr_o=5.
- Stream 4 instructions back-to-back, ready_i=1 throughout -> valid_o held 4 consecutive cycles, payloads in order, ready_o always 1.
- ready_i=0 while sending A,B -> ready_o=0 after B (FULL); raise ready_i -> A then B drained in order, ready_o=1 after A drains.
- FULL state, assert flush_i with valid_i=1 -> next cycle valid_o=0, ready_o=1, fwd_en_o=0; incoming instruction discarded.
- writeaddr_i=0, wb_i[0]=1 -> valid_o=1 but fwd_en_o=0; wb_i[0]=0, writeaddr_i=7 -> fwd_en_o=0.
- With EX_MEM_STALL_CNT_EN: hold ready_i=0 for 10 cycles with valid_o=1 -> stall_cnt_o=10; flush -> still 10; rst_i -> 0.
